// File: rtl/varint_zigzag_encoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : varint_zigzag_encoder
// Purpose  : Registered protobuf varint encoder with optional ZigZag
//            pre-encoding for sint32/sint64 fields. It accepts one 64-bit
//            field value per cycle and produces the varint byte image one
//            cycle later. Byte 0 is the least significant byte and is
//            emitted first.
// Ports    : clk         - clock; all state updates on the rising edge
//            reset       - synchronous, active-low reset
//            in_valid    - qualifies in_val, zz_en and is_32
//            in_val      - raw 64-bit field value
//            zz_en       - apply ZigZag encoding (sint32/sint64)
//            is_32       - treat the value as a 32-bit field
//            out_valid   - high one cycle after an accepted input
//            out_port    - varint image; byte k is out_port[8k+7:8k]
//            out_len     - number of meaningful bytes, 1..10
//            out_byte_en - per-byte enables, bit k = (k < out_len)
//                          (present only with VARINT_BYTE_MASK_EN)
// Options  : VARINT_BYTE_MASK_EN - adds the out_byte_en output
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module varint_zigzag_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_val,
    input  logic        zz_en,
    input  logic        is_32,
`ifdef VARINT_BYTE_MASK_EN
    output logic [9:0]  out_byte_en,
`endif
    output logic        out_valid,
    output logic [79:0] out_port,
    output logic [3:0]  out_len
);

    localparam int unsigned C_MAX_BYTES = 10;

    logic [63:0] w_n;
    logic [69:0] w_pad;
    logic [3:0]  w_len;
    logic [79:0] w_bytes;
    logic [9:0]  w_byte_en;

    logic        r_valid;
    logic [79:0] r_port;
    logic [3:0]  r_len;
    logic [9:0]  r_byte_en;

    // Normalisation. For 32-bit fields the upper word is discarded so that
    // sign-extended negative int32 values encode in 5 bytes, not 10.
    always_comb begin
        w_n = in_val;
        if (zz_en && is_32) begin
            w_n = {32'h0, (in_val[31:0] << 1) ^ {32{in_val[31]}}};
        end else if (zz_en) begin
            w_n = (in_val << 1) ^ {64{in_val[63]}};
        end else if (is_32) begin
            w_n = {32'h0, in_val[31:0]};
        end
    end

    // Pad to 70 bits so group 9 (bit 63 only) can be sliced like the others.
    assign w_pad = {6'b0, w_n};

    // Length is one past the highest nonzero 7-bit group; a zero value still
    // occupies one byte.
    always_comb begin
        w_len = 4'd1;
        for (int k = 1; k < C_MAX_BYTES; k++) begin
            if (w_pad[7*k +: 7] != 7'd0) begin
                w_len = 4'(k + 1);
            end
        end
    end

    // Bit 7 of each byte is the continuation flag: set on every byte except
    // the last meaningful one. Bytes beyond the length are forced to zero.
    always_comb begin
        w_bytes   = '0;
        w_byte_en = '0;
        for (int k = 0; k < C_MAX_BYTES; k++) begin
            if (4'(k) < w_len) begin
                w_bytes[8*k +: 8] = {(4'(k) < (w_len - 4'd1)), w_pad[7*k +: 7]};
                w_byte_en[k]      = 1'b1;
            end
        end
    end

    // Data registers only load on an accepted input so the last result stays
    // visible while the input stream idles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_port    <= '0;
            r_len     <= '0;
            r_byte_en <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_port    <= w_bytes;
                r_len     <= w_len;
                r_byte_en <= w_byte_en;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_port  = r_port;
    assign out_len   = r_len;

`ifdef VARINT_BYTE_MASK_EN
    assign out_byte_en = r_byte_en;
`else
    // Without the byte-enable output the register is unobserved and is
    // removed by synthesis; this keeps the lint view free of unused bits.
    logic w_unused_byte_en;
    assign w_unused_byte_en = ^r_byte_en;
`endif

endmodule
`default_nettype wire

// File: tb/tb_varint_zigzag_encoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_varint_zigzag_encoder
// Purpose  : Directed self-checking bench for varint_zigzag_encoder with
//            hand-computed expected byte images and lengths.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_varint_zigzag_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_val;
    logic        zz_en;
    logic        is_32;
    logic        out_valid;
    logic [79:0] out_port;
    logic [3:0]  out_len;
`ifdef VARINT_BYTE_MASK_EN
    logic [9:0]  out_byte_en;
`endif

    int vectors;
    int miscompares;

    varint_zigzag_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_val      (in_val),
        .zz_en       (zz_en),
        .is_32       (is_32),
`ifdef VARINT_BYTE_MASK_EN
        .out_byte_en (out_byte_en),
`endif
        .out_valid   (out_valid),
        .out_port    (out_port),
        .out_len     (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] val,
                         input logic zz, input logic w32);
        in_valid = v;
        in_val   = val;
        zz_en    = zz;
        is_32    = w32;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 64'd5, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0 || out_port !== 80'h0 || out_len !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: valid=%b port=%h len=%0d want 0/0/0",
                         c, out_valid, out_port, out_len);
            end
        end
        reset = 1'b1;
        drive(1'b1, 64'd300, 1'b0, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_port !== 80'h02AC || out_len !== 4'd2) begin
            miscompares++;
            $display("FAIL reset_release_300: valid=%b port=%h len=%0d want 1/02ac/2",
                     out_valid, out_port, out_len);
        end
    endtask

    task automatic test_unsigned();
        drive(1'b1, 64'd0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_port !== 80'h0 || out_len !== 4'd1) begin
            miscompares++;
            $display("FAIL zero: valid=%b port=%h len=%0d want 1/0/1",
                     out_valid, out_port, out_len);
        end
`ifdef VARINT_BYTE_MASK_EN
        vectors++;
        if (out_byte_en !== 10'h001) begin
            miscompares++;
            $display("FAIL zero_byte_en: got %h want 001", out_byte_en);
        end
`endif
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        tick();
        vectors++;
        if (out_port !== 80'h01_FFFF_FFFF_FFFF_FFFF_FF || out_len !== 4'd10) begin
            miscompares++;
            $display("FAIL all_ones64: port=%h len=%0d want 01ffffffffffffffffff/10",
                     out_port, out_len);
        end
`ifdef VARINT_BYTE_MASK_EN
        vectors++;
        if (out_byte_en !== 10'h3FF) begin
            miscompares++;
            $display("FAIL all_ones64_byte_en: got %h want 3ff", out_byte_en);
        end
`endif
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        tick();
        vectors++;
        if (out_port !== 80'h01_8080_8080_8080_8080_80 || out_len !== 4'd10) begin
            miscompares++;
            $display("FAIL pow2_63: port=%h len=%0d want 01808080808080808080/10",
                     out_port, out_len);
        end
    endtask

    task automatic test_zigzag();
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        tick();
        vectors++;
        if (out_port !== 80'h01 || out_len !== 4'd1) begin
            miscompares++;
            $display("FAIL zz64_minus1: port=%h len=%0d want 01/1", out_port, out_len);
        end
        drive(1'b1, 64'd1, 1'b1, 1'b0);
        tick();
        vectors++;
        if (out_port !== 80'h02 || out_len !== 4'd1) begin
            miscompares++;
            $display("FAIL zz64_plus1: port=%h len=%0d want 02/1", out_port, out_len);
        end
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
        tick();
        vectors++;
        if (out_port !== 80'h03 || out_len !== 4'd1) begin
            miscompares++;
            $display("FAIL zz32_minus2: port=%h len=%0d want 03/1", out_port, out_len);
        end
        drive(1'b1, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1);
        tick();
        vectors++;
        if (out_port !== 80'h0F_FFFF_FFFE || out_len !== 4'd5) begin
            miscompares++;
            $display("FAIL zz32_max: port=%h len=%0d want 0ffffffffe/5", out_port, out_len);
        end
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1);
        tick();
        vectors++;
        if (out_port !== 80'h02 || out_len !== 4'd1) begin
            miscompares++;
            $display("FAIL zz32_upper_ignored: port=%h len=%0d want 02/1", out_port, out_len);
        end
    endtask

    task automatic test_mask32();
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        tick();
        vectors++;
        if (out_port !== 80'h0F_FFFF_FFFF || out_len !== 4'd5) begin
            miscompares++;
            $display("FAIL mask32: port=%h len=%0d want 0fffffffff/5", out_port, out_len);
        end
`ifdef VARINT_BYTE_MASK_EN
        vectors++;
        if (out_byte_en !== 10'h01F) begin
            miscompares++;
            $display("FAIL mask32_byte_en: got %h want 01f", out_byte_en);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [4];
        logic [79:0] exp_port [4];
        logic [3:0]  exp_len [4];
        vals[0] = 64'd1;     exp_port[0] = 80'h01;     exp_len[0] = 4'd1;
        vals[1] = 64'd127;   exp_port[1] = 80'h7F;     exp_len[1] = 4'd1;
        vals[2] = 64'd128;   exp_port[2] = 80'h0180;   exp_len[2] = 4'd2;
        vals[3] = 64'd16384; exp_port[3] = 80'h018080; exp_len[3] = 4'd3;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_port !== exp_port[i] || out_len !== exp_len[i]) begin
                miscompares++;
                $display("FAIL b2b[%0d]: valid=%b port=%h len=%0d want 1/%h/%0d",
                         i, out_valid, out_port, out_len, exp_port[i], exp_len[i]);
            end
        end
        drive(1'b0, 64'd5, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0 || out_port !== 80'h018080 || out_len !== 4'd3) begin
                miscompares++;
                $display("FAIL idle_hold cyc%0d: valid=%b port=%h len=%0d want 0/018080/3",
                         c, out_valid, out_port, out_len);
            end
        end
`ifdef VARINT_BYTE_MASK_EN
        vectors++;
        if (out_byte_en !== 10'h007) begin
            miscompares++;
            $display("FAIL idle_hold_byte_en: got %h want 007", out_byte_en);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 64'd300, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b1, 64'd128, 1'b0, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_port !== 80'h0 || out_len !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b port=%h len=%0d want 0/0/0",
                     out_valid, out_port, out_len);
        end
`ifdef VARINT_BYTE_MASK_EN
        vectors++;
        if (out_byte_en !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_mid_byte_en: got %h want 000", out_byte_en);
        end
`endif
        reset = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0 || out_port !== 80'h0 || out_len !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_mid_after cyc%0d: valid=%b port=%h len=%0d want 0/0/0",
                         c, out_valid, out_port, out_len);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_unsigned();
        test_zigzag();
        test_mask32();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
